hdmi_wr_packer: RTL

HDMI_WR_PACKER -- requirements
Module: hdmi_wr_packer

---
 rtl/hdmi_wr_packer_pkg.sv | 22 ++
 rtl/hdmi_wr_packer_fifo.sv | 69 ++++++
 rtl/hdmi_wr_packer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_wr_packer_pkg.sv
// hdmi_wr_packer_pkg
// Shared constants for the HDMI capture write packer: word geometry,
// pixel geometry and the burst FSM state encoding.
// No ports (package).

package hdmi_wr_packer_pkg;

    localparam int WORD_W       = 128;
    localparam int PIX_W        = 16;
    localparam int PIX_PER_WORD = 8;

    // Burst FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Bit offset of a pixel slot inside a packed word (slot * 16)
    function automatic logic [6:0] pix_lsb(input logic [2:0] slot);
        return {slot, 4'b0000};
    endfunction

endpackage

// File: rtl/hdmi_wr_packer_fifo.sv
// sync_word_fifo
// Single-clock word FIFO with show-ahead output (rd_data always shows the
// head word), occupancy count, full/empty flags and a one-cycle flush.
// A write while full, or any write/read during flush, is ignored.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   flush        : empty the FIFO this cycle (wins over wr_en/rd_en)
//   wr_en/wr_data: push a word
//   rd_en        : pop the head word
//   rd_data      : head word (valid when !empty)
//   count        : words held, 0..DEPTH
//   full, empty  : occupancy flags

module sync_word_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    // Pointers carry one extra wrap bit so full and empty stay distinct
    assign count   = wr_ptr_r - rd_ptr_r;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == {(AW + 1){1'b0}});
    assign wr_ok_s = wr_en & ~full & ~flush;
    assign rd_ok_s = rd_en & ~empty & ~flush;
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointer update, flush clears both
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
            end
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/hdmi_wr_packer.sv
// hdmi_wr_packer
// Packs RGB565 capture pixels eight at a time into 128-bit words, buffers
// them in a word FIFO and writes them to a double-buffered frame store in
// fixed-length bursts (request/ack handshake, then a valid/ready data phase).
// Each frame start flips to the other frame buffer once any burst in
// flight has finished.
// Ports:
//   clk, rst                 : pixel clock, synchronous active-high reset
//   pix_data, pix_valid      : incoming pixel stream (no backpressure)
//   frame_en                 : capture level; rise = frame start, fall = end
//   wr_req, wr_addr, wr_ack  : burst request handshake, byte address
//   wr_data, wr_data_valid,
//   wr_data_ready            : burst data beats
//   frame_done, done_buf     : end-of-frame pulse and finished buffer index
//   overflow                 : sticky, a packed word was lost to a full FIFO

module hdmi_wr_packer
    import hdmi_wr_packer_pkg::*;
#(
    parameter int                ADDR_W     = 28,
    parameter int                BURST_LEN  = 16,
    parameter int                FIFO_DEPTH = 32,
    parameter logic [ADDR_W-1:0] BUF0_BASE  = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] BUF_STRIDE = 28'h0400000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_valid,
    input  logic              frame_en,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ack,
    output logic [WORD_W-1:0] wr_data,
    output logic              wr_data_valid,
    input  logic              wr_data_ready,
    output logic              frame_done,
    output logic              done_buf,
    output logic              overflow
);

    localparam int                CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int                BEAT_W      = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0]  BURST_WORDS = CNT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * (WORD_W / 8));
    localparam logic [2:0]        LAST_SLOT   = 3'(PIX_PER_WORD - 1);

    // Pixel packer
    logic              frame_en_d_r;
    logic [2:0]        pack_cnt_r;
    logic [WORD_W-1:0] pack_word_r;
    logic              word_valid_r;

    // Burst engine
    logic [1:0]        state_r;
    logic [BEAT_W-1:0] beat_cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wr_buf_r;
    logic              pending_r;
    logic              wr_req_r;
    logic              wr_data_valid_r;

    // Status
    logic              frame_done_r;
    logic              done_buf_r;
    logic              overflow_r;

    // Combinational
    logic              rise_s;
    logic              fall_s;
    logic              flush_s;
    logic              pop_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    assign rise_s  = frame_en & ~frame_en_d_r;
    assign fall_s  = ~frame_en & frame_en_d_r;
    // A frame start is only serviced between bursts, never mid-burst
    assign flush_s = (state_r == ST_IDLE) & pending_r;
    assign pop_s   = (state_r == ST_DATA) & wr_data_valid_r & wr_data_ready & ~fifo_empty_s;

    assign wr_req        = wr_req_r;
    assign wr_addr       = addr_r;
    assign wr_data_valid = wr_data_valid_r;
    assign frame_done    = frame_done_r;
    assign done_buf      = done_buf_r;
    assign overflow      = overflow_r;

    sync_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_s),
        .wr_en   (word_valid_r),
        .wr_data (pack_word_r),
        .rd_en   (pop_s),
        .rd_data (wr_data),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Pixel packing; the completed word is pushed the cycle after slot 7 fills.
    // A frame start drops any partial word: stale slots are simply overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_cnt_r   <= 3'd0;
            pack_word_r  <= {WORD_W{1'b0}};
            word_valid_r <= 1'b0;
        end else begin
            word_valid_r <= 1'b0;
            if (rise_s) begin
                pack_cnt_r <= 3'd0;
            end else if (pix_valid) begin
                pack_word_r[pix_lsb(pack_cnt_r) +: PIX_W] <= pix_data;
                pack_cnt_r   <= pack_cnt_r + 3'd1;
                word_valid_r <= (pack_cnt_r == LAST_SLOT);
            end
        end
    end

    // Burst FSM, buffer selection and write address
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            beat_cnt_r      <= {BEAT_W{1'b0}};
            addr_r          <= BUF0_BASE;
            wr_buf_r        <= 1'b1;
            pending_r       <= 1'b0;
            wr_req_r        <= 1'b0;
            wr_data_valid_r <= 1'b0;
        end else begin
            if (rise_s) begin
                pending_r <= 1'b1;
            end else if (flush_s) begin
                pending_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (pending_r) begin
                        // New buffer is ~wr_buf_r: old 1 -> buffer 0 at base
                        wr_buf_r <= ~wr_buf_r;
                        addr_r   <= wr_buf_r ? BUF0_BASE : (BUF0_BASE + BUF_STRIDE);
                    end else if (fifo_count_s >= BURST_WORDS) begin
                        state_r  <= ST_REQ;
                        wr_req_r <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (wr_ack) begin
                        state_r         <= ST_DATA;
                        wr_req_r        <= 1'b0;
                        wr_data_valid_r <= 1'b1;
                        beat_cnt_r      <= {BEAT_W{1'b0}};
                    end
                end
                ST_DATA: begin
                    if (pop_s) begin
                        if (beat_cnt_r == LAST_BEAT) begin
                            state_r         <= ST_IDLE;
                            wr_data_valid_r <= 1'b0;
                            beat_cnt_r      <= {BEAT_W{1'b0}};
                            addr_r          <= addr_r + BURST_BYTES;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    wr_req_r        <= 1'b0;
                    wr_data_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Frame edge tracking, frame-done pulse and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_en_d_r <= 1'b0;
            frame_done_r <= 1'b0;
            done_buf_r   <= 1'b1;
            overflow_r   <= 1'b0;
        end else begin
            frame_en_d_r <= frame_en;
            frame_done_r <= fall_s;
            if (fall_s) begin
                done_buf_r <= wr_buf_r;
            end
            // A word colliding with a flush is dropped silently, not an overflow
            if (word_valid_r && fifo_full_s && !flush_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

endmodule
